// File: rtl/mips_isa_pkg.sv
// MIPS opcode/func encodings and the decoded-entry record shared by the decode stage.
package mips_isa_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] MUL_OP     = 6'h1C;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] MUL_FUNC = 6'h02;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] func;
    logic [4:0] dest_reg;
    logic       reg_write;
    logic       illegal;
  } dec_fields_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational decode of one instruction word and its pc.
module decode_comb
  import mips_isa_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int IMM_WIDTH  = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic [31:0]          insn,
  input  logic [PC_WIDTH-1:0]  pc,
  output dec_fields_t          fields,
  output logic [IMM_WIDTH-1:0] imm,
  output logic [PC_WIDTH-1:0]  branch_target,
  output logic [PC_WIDTH-1:0]  jump_target
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sa;
  logic [IMM_WIDTH-1:0] imm_s, imm_z;
  logic [PC_WIDTH-1:0]  pc4;

  assign op    = insn[31:26];
  assign rs    = insn[25:21];
  assign rt    = insn[20:16];
  assign rd    = insn[15:11];
  assign sa    = insn[10:6];
  assign fn    = insn[5:0];
  assign imm_s = IMM_WIDTH'($signed(insn[15:0]));
  assign imm_z = IMM_WIDTH'(insn[15:0]);
  assign pc4   = pc + PC_WIDTH'(4);
  assign branch_target = pc4 + (PC_WIDTH'($signed(insn[15:0])) << 2);

  // Low 28 bits replaced in place so PC_WIDTH == 28 needs no empty slice.
  always_comb begin
    jump_target       = pc4;
    jump_target[27:0] = {insn[25:0], 2'b00};
  end

  always_comb begin
    fields        = '0;
    fields.opcode = op;
    imm           = '0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: begin
            fields.rt = rt; fields.rd = rd; fields.sa = sa;
            fields.func = fn; fields.dest_reg = rd;
          end
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            fields.rs = rs; fields.rt = rt; fields.rd = rd;
            fields.func = fn; fields.dest_reg = rd;
          end
          FN_JR: begin
            fields.rs = rs; fields.func = fn;
          end
          FN_JALR: begin
            fields.rs = rs; fields.rd = rd; fields.func = fn; fields.dest_reg = rd;
          end
          FN_MFHI, FN_MFLO: begin
            fields.rd = rd; fields.func = fn; fields.dest_reg = rd;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            fields.rs = rs; fields.rt = rt; fields.func = fn;
          end
          default: fields.illegal = 1'b1;
        endcase
      end
      MUL_OP: begin
        if (ENABLE_MUL && fn == MUL_FUNC) begin
          fields.rs = rs; fields.rt = rt; fields.rd = rd;
          fields.func = fn; fields.dest_reg = rd;
        end else begin
          fields.illegal = 1'b1;
        end
      end
      OP_J: begin
      end
      OP_JAL: fields.dest_reg = 5'd31;
      OP_BEQ, OP_BNE, OP_SW, OP_SB: begin
        fields.rs = rs; fields.rt = rt; imm = imm_s;
      end
      OP_BGTZ: begin
        fields.rs = rs; imm = imm_s;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_LB, OP_LBU: begin
        fields.rs = rs; fields.rt = rt; imm = imm_s; fields.dest_reg = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        fields.rs = rs; fields.rt = rt; imm = imm_z; fields.dest_reg = rt;
      end
      OP_LUI: begin
        fields.rt = rt; imm = imm_z; fields.dest_reg = rt;
      end
      default: fields.illegal = 1'b1;
    endcase
    fields.reg_write = !fields.illegal && (fields.dest_reg != 5'd0);
  end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined decode stage: one decoder feeding a main output register plus a skid slot.
module decode_pipe
  import mips_isa_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int IMM_WIDTH  = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          insn,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           opcode_out,
  output logic [4:0]           rs_out,
  output logic [4:0]           rt_out,
  output logic [4:0]           rd_out,
  output logic [4:0]           sa_out,
  output logic [5:0]           func_out,
  output logic [IMM_WIDTH-1:0] imm_out,
  output logic [PC_WIDTH-1:0]  branch_target,
  output logic [PC_WIDTH-1:0]  jump_target,
  output logic [4:0]           dest_reg,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [PC_WIDTH-1:0]  pc_out
);

  typedef struct packed {
    dec_fields_t           f;
    logic [IMM_WIDTH-1:0]  imm;
    logic [PC_WIDTH-1:0]   bt;
    logic [PC_WIDTH-1:0]   jt;
    logic [PC_WIDTH-1:0]   pc;
  } slot_t;

  slot_t in_slot, main_q, skid_q;
  logic  main_valid, skid_valid;

  decode_comb #(
    .PC_WIDTH  (PC_WIDTH),
    .IMM_WIDTH (IMM_WIDTH),
    .ENABLE_MUL(ENABLE_MUL)
  ) u_dec (
    .insn         (insn),
    .pc           (pc),
    .fields       (in_slot.f),
    .imm          (in_slot.imm),
    .branch_target(in_slot.bt),
    .jump_target  (in_slot.jt)
  );
  assign in_slot.pc = pc;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;

  // Accept implies an empty skid, so the main-free branch only checks in_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_valid) begin
        main_q     <= in_slot;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_valid && !skid_valid) begin
      skid_q     <= in_slot;
      skid_valid <= 1'b1;
    end
  end

  assign opcode_out    = main_q.f.opcode;
  assign rs_out        = main_q.f.rs;
  assign rt_out        = main_q.f.rt;
  assign rd_out        = main_q.f.rd;
  assign sa_out        = main_q.f.sa;
  assign func_out      = main_q.f.func;
  assign dest_reg      = main_q.f.dest_reg;
  assign reg_write     = main_q.f.reg_write;
  assign illegal       = main_q.f.illegal;
  assign imm_out       = main_q.imm;
  assign branch_target = main_q.bt;
  assign jump_target   = main_q.jt;
  assign pc_out        = main_q.pc;

endmodule
